// File: rtl/variable_pkg.sv
// Shared game constants and types for the turn scheduler.
// ON/OFF, player ids, hp width and the turn FSM state enum.
package variable_pkg;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam logic PLAYER0 = 1'b0;
    localparam logic PLAYER1 = 1'b1;

    localparam int HP_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AIM,
        ST_FLIGHT,
        ST_SETTLE,
        ST_GAME_OVER
    } turn_state_t;

endpackage

// File: rtl/turn_timer.sv
// Aim timer: loadable whole-second down-counter behind a tick prescaler.
// Ports: clk60MHz, rst, load, run -> time_left[3:0], expire (comb pulse).
module turn_timer #(
    parameter int TICKS_PER_SEC = 60_000_000,
    parameter int TURN_SEC      = 10
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       load,
    input  logic       run,
    output logic [3:0] time_left,
    output logic       expire
);

    localparam int CW =
        (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    SEC_INIT  = 4'(TURN_SEC);

    logic [CW-1:0] tick_cnt;
    logic          wrap;

    assign wrap   = run && (tick_cnt == TICK_LAST);
    // Expiry is the wrap of the last (zero) second.
    assign expire = wrap && (time_left == 4'd0);

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            tick_cnt  <= '0;
            time_left <= '0;
        end else if (load) begin
            tick_cnt  <= '0;
            time_left <= SEC_INIT;
        end else if (wrap) begin
            tick_cnt <= '0;
            if (time_left != 4'd0)
                time_left <= time_left - 4'd1;
        end else if (run) begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Two-player turn sequencer: aim timer, flight tracking, scoring, game over.
// Ports: clk60MHz, rst, start_game, throw_flag, end_throw, hit ->
//   turn, hp0, hp1, aim_en, time_left, timeout, game_over, winner.
// Optional TURN_SCHEDULER_WIND_EN adds signed wind[3:0] from a 16-bit LFSR.
module turn_scheduler
    import variable_pkg::*;
#(
    parameter int TICKS_PER_SEC = 60_000_000,
    parameter int TURN_SEC      = 10,
    parameter int SETTLE_CYCLES = 30_000_000,
    parameter int HP_MAX        = 3
) (
    input  logic            clk60MHz,
    input  logic            rst,
    input  logic            start_game,
    input  logic            throw_flag,
    input  logic            end_throw,
    input  logic            hit,
    output logic            turn,
    output logic [HP_W-1:0] hp0,
    output logic [HP_W-1:0] hp1,
    output logic            aim_en,
    output logic [3:0]      time_left,
    output logic            timeout,
    output logic            game_over,
    output logic            winner
`ifdef TURN_SCHEDULER_WIND_EN
    ,
    output logic signed [3:0] wind
`endif
);

    localparam int SW =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [HP_W-1:0] HP_INIT     = HP_W'(HP_MAX);

    turn_state_t     state, state_d;
    logic            turn_d, winner_d, timeout_d;
    logic [HP_W-1:0] hp0_d, hp1_d;
    logic [SW-1:0]   settle_cnt, settle_d;
    logic            tmr_load, tmr_expire;

    turn_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .TURN_SEC     (TURN_SEC)
    ) u_timer (
        .clk60MHz (clk60MHz),
        .rst      (rst),
        .load     (tmr_load),
        .run      (state == ST_AIM),
        .time_left(time_left),
        .expire   (tmr_expire)
    );

    assign aim_en    = (state == ST_AIM);
    assign game_over = (state == ST_GAME_OVER);

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state      <= ST_IDLE;
            turn       <= PLAYER0;
            hp0        <= HP_INIT;
            hp1        <= HP_INIT;
            timeout    <= OFF;
            winner     <= PLAYER0;
            settle_cnt <= '0;
        end else begin
            state      <= state_d;
            turn       <= turn_d;
            hp0        <= hp0_d;
            hp1        <= hp1_d;
            timeout    <= timeout_d;
            winner     <= winner_d;
            settle_cnt <= settle_d;
        end
    end

    always_comb begin
        state_d   = state;
        turn_d    = turn;
        hp0_d     = hp0;
        hp1_d     = hp1;
        winner_d  = winner;
        settle_d  = settle_cnt;
        timeout_d = OFF;
        tmr_load  = OFF;
        unique case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_game) begin
                    state_d  = ST_AIM;
                    turn_d   = PLAYER0;
                    hp0_d    = HP_INIT;
                    hp1_d    = HP_INIT;
                    winner_d = PLAYER0;
                    tmr_load = ON;
                end
            end
            ST_AIM: begin
                // A throw beats an expiry landing on the same cycle.
                if (throw_flag) begin
                    state_d = ST_FLIGHT;
                end else if (tmr_expire) begin
                    timeout_d = ON;
                    state_d   = ST_SETTLE;
                    settle_d  = SETTLE_INIT;
                end
            end
            ST_FLIGHT: begin
                if (end_throw) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_INIT;
                    if (hit) begin
                        if (turn == PLAYER0) begin
                            if (hp1 != '0)
                                hp1_d = hp1 - HP_W'(1);
                        end else begin
                            if (hp0 != '0)
                                hp0_d = hp0 - HP_W'(1);
                        end
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    if (hp0 == '0 || hp1 == '0) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = turn;
                    end else begin
                        state_d  = ST_AIM;
                        turn_d   = ~turn;
                        tmr_load = ON;
                    end
                end else begin
                    settle_d = settle_cnt - SW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef TURN_SCHEDULER_WIND_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            lfsr <= 16'hACE1;
            wind <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (tmr_load)
                wind <= lfsr[3:0];
        end
    end
`else
    // No wind source in this build.
`endif

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed self-checking bench for turn_scheduler.
// Small timing parameters keep every phase a few dozen cycles long.
module tb_turn_scheduler;
    import variable_pkg::*;

    logic            clk60MHz = 1'b0;
    logic            rst;
    logic            start_game;
    logic            throw_flag;
    logic            end_throw;
    logic            hit;
    logic            turn;
    logic [HP_W-1:0] hp0;
    logic [HP_W-1:0] hp1;
    logic            aim_en;
    logic [3:0]      time_left;
    logic            timeout;
    logic            game_over;
    logic            winner;
`ifdef TURN_SCHEDULER_WIND_EN
    logic signed [3:0] wind;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk60MHz = ~clk60MHz;

    turn_scheduler #(
        .TICKS_PER_SEC(10),
        .TURN_SEC     (3),
        .SETTLE_CYCLES(4),
        .HP_MAX       (2)
    ) dut (
        .clk60MHz  (clk60MHz),
        .rst       (rst),
        .start_game(start_game),
        .throw_flag(throw_flag),
        .end_throw (end_throw),
        .hit       (hit),
        .turn      (turn),
        .hp0       (hp0),
        .hp1       (hp1),
        .aim_en    (aim_en),
        .time_left (time_left),
        .timeout   (timeout),
        .game_over (game_over),
        .winner    (winner)
`ifdef TURN_SCHEDULER_WIND_EN
        ,
        .wind      (wind)
`endif
    );

    task automatic step();
        @(posedge clk60MHz);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_turn"}, 8'(turn), 8'd0);
        chk({tag, "_hp0"}, 8'(hp0), 8'd2);
        chk({tag, "_hp1"}, 8'(hp1), 8'd2);
        chk({tag, "_aim"}, 8'(aim_en), 8'd0);
        chk({tag, "_tl"}, 8'(time_left), 8'd0);
        chk({tag, "_to"}, 8'(timeout), 8'd0);
        chk({tag, "_go"}, 8'(game_over), 8'd0);
        chk({tag, "_win"}, 8'(winner), 8'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start_game = 1'b0;
        throw_flag = 1'b0;
        end_throw  = 1'b0;
        hit        = 1'b0;
        step();
        step();
        chk_reset("rst");
        rst = 1'b0;
        step();
        chk("idle_aim", 8'(aim_en), 8'd0);

        // Start: AIM for player0
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        chk("start_aim", 8'(aim_en), 8'd1);
        chk("start_turn", 8'(turn), 8'd0);
        chk("start_tl", 8'(time_left), 8'd3);
        chk("start_hp0", 8'(hp0), 8'd2);
        chk("start_hp1", 8'(hp1), 8'd2);

        // end_throw in AIM ignored
        end_throw = 1'b1;
        hit       = 1'b1;
        step();
        end_throw = 1'b0;
        hit       = 1'b0;
        chk("aim_endthrow_hp1", 8'(hp1), 8'd2);
        chk("aim_endthrow_aim", 8'(aim_en), 8'd1);

        // Throw and hit
        throw_flag = 1'b1;
        step();
        throw_flag = 1'b0;
        chk("throw_aim", 8'(aim_en), 8'd0);
        chk("throw_tl", 8'(time_left), 8'd3);
        repeat (4) step();
        chk("flight_hold", 8'(aim_en), 8'd0);
        end_throw = 1'b1;
        hit       = 1'b1;
        step();
        end_throw = 1'b0;
        hit       = 1'b0;
        chk("hit1_hp1", 8'(hp1), 8'd1);
        chk("hit1_hp0", 8'(hp0), 8'd2);
        repeat (3) step();
        chk("settle_turn", 8'(turn), 8'd0);
        step();
        chk("switch_turn", 8'(turn), 8'd1);
        chk("switch_tl", 8'(time_left), 8'd3);
        chk("switch_aim", 8'(aim_en), 8'd1);

        // Player1 times out: 4 seconds of 10 ticks
        repeat (10) step();
        chk("tl_dec", 8'(time_left), 8'd2);
        repeat (29) step();
        chk("pre_to_tl", 8'(time_left), 8'd0);
        chk("pre_to", 8'(timeout), 8'd0);
        step();
        chk("to_pulse", 8'(timeout), 8'd1);
        chk("to_aim", 8'(aim_en), 8'd0);
        chk("to_hp0", 8'(hp0), 8'd2);
        chk("to_hp1", 8'(hp1), 8'd1);
        step();
        chk("to_once", 8'(timeout), 8'd0);
        repeat (3) step();
        chk("to_turn", 8'(turn), 8'd0);
        chk("to_tl", 8'(time_left), 8'd3);

        // Throw on the expiry cycle wins
        repeat (39) step();
        throw_flag = 1'b1;
        step();
        throw_flag = 1'b0;
        chk("race_to", 8'(timeout), 8'd0);
        chk("race_aim", 8'(aim_en), 8'd0);
        end_throw = 1'b1;
        hit       = 1'b1;
        step();
        end_throw = 1'b0;
        hit       = 1'b0;
        chk("race_to2", 8'(timeout), 8'd0);
        chk("hit2_hp1", 8'(hp1), 8'd0);
        repeat (3) step();
        chk("pre_go", 8'(game_over), 8'd0);
        step();
        chk("go", 8'(game_over), 8'd1);
        chk("go_winner", 8'(winner), 8'd0);
        chk("go_aim", 8'(aim_en), 8'd0);

        // Held in GAME_OVER; stray end_throw ignored
        end_throw = 1'b1;
        hit       = 1'b1;
        step();
        end_throw = 1'b0;
        hit       = 1'b0;
        step();
        chk("go_hold", 8'(game_over), 8'd1);
        chk("go_hp0", 8'(hp0), 8'd2);
        chk("go_hp1", 8'(hp1), 8'd0);

        // Restart
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        chk("re_go", 8'(game_over), 8'd0);
        chk("re_hp1", 8'(hp1), 8'd2);
        chk("re_turn", 8'(turn), 8'd0);
        chk("re_tl", 8'(time_left), 8'd3);

        // Player0 misses
        throw_flag = 1'b1;
        step();
        throw_flag = 1'b0;
        end_throw  = 1'b1;
        step();
        end_throw = 1'b0;
        chk("miss_hp1", 8'(hp1), 8'd2);
        repeat (4) step();
        chk("miss_turn", 8'(turn), 8'd1);

        // Player1 hits player0
        throw_flag = 1'b1;
        step();
        throw_flag = 1'b0;
        end_throw  = 1'b1;
        hit        = 1'b1;
        step();
        end_throw = 1'b0;
        hit       = 1'b0;
        chk("p1hit_hp0", 8'(hp0), 8'd1);
        chk("p1hit_hp1", 8'(hp1), 8'd2);
        repeat (4) step();
        chk("p1hit_turn", 8'(turn), 8'd0);

        // Reset in FLIGHT with a coincident hit
        throw_flag = 1'b1;
        step();
        chk("rstf_aim", 8'(aim_en), 8'd0);
        rst       = 1'b1;
        end_throw = 1'b1;
        hit       = 1'b1;
        step();
        chk_reset("rstf");
        rst        = 1'b0;
        throw_flag = 1'b0;
        end_throw  = 1'b0;
        hit        = 1'b0;
        step();
        chk("post_rst_aim", 8'(aim_en), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
